alu_cmd_queue: RTL and testbench
================================

# alu_cmd_queue

- Command buffer and issue stage directly upstream of the 13-bit ALU.
- Accepts operand/opcode commands over a valid/ready handshake into a small FIFO and drives the ALU's `x`, `y` and `opcode` inputs from registers, one command per cycle.
- Provides a `res_valid` strobe aligned with the ALU's registered `result`/`status`.
- Optionally guards divide/modulo-by-zero before issue.

## Interface
- `WIDTH`, 13: operand width; must match the ALU.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `aclk` input 1: clock; all logic on the rising edge.
- `areset` input 1: synchronous, active-high reset.
- `in_valid` input 1: upstream command present.
- `in_ready` output 1: queue can accept. Combinational: 0 while `areset` is high, else `!full`.
- `in_x` input WIDTH: operand x.
- `in_y` input WIDTH: operand y.
- `in_opcode` input 3: ALU opcode.
- `stall` input 1: downstream hold; while high, nothing is issued and `out_*` hold their values.
- `out_x` output WIDTH: registered, drives ALU `x`.
- `out_y` output WIDTH: registered, drives ALU `y`.
- `out_opcode` output 3: registered, drives ALU `opcode`.
- `out_valid` output 1: `out_*` carry a newly issued command this cycle.
- `res_valid` output 1: ALU `result`/`status` hold that command's outcome this cycle.
- `div0_err` output 1: issued command was divide/modulo by zero (guard build only).
- `count` output $clog2(DEPTH+1): current FIFO occupancy.

## Operation
- **Push:** when `in_valid && in_ready`, write {x, y, opcode} at `wr_ptr`, then increment `wr_ptr` modulo DEPTH.
- **Pop/issue:** when `!stall && count != 0`:
  - load the head entry into `out_x`/`out_y`/`out_opcode`;
  - set `out_valid` = 1;
  - increment `rd_ptr` modulo DEPTH.
- **No pop:** `out_valid` = 0 and `out_x`/`out_y`/`out_opcode` hold their last values, so the ALU keeps recomputing the same command.
- **Full/empty:** full when `count == DEPTH`; empty when `count == 0`.
- **Simultaneous push and pop:** `count` is unchanged. Both are permitted at any non-full occupancy. When full, no push occurs because `in_ready` = 0.
- **Empty with push:** there is no bypass. The entry is written first and issued on the next cycle at the earliest.
- **Pointer wrap:** pointers wrap from DEPTH-1 to 0. FIFO order is preserved across the wrap.
- **`res_valid`:** `out_valid` delayed by one register stage, matching the ALU's single register stage.
- **Operand arithmetic:** none. Operands and opcode pass unmodified except under the guard.
- **Reset mid-operation:** `areset` high at an edge discards all queued entries and clears every output, regardless of `stall` or `in_valid`. A `res_valid` that was pending is dropped.

## Timing
- **Reset values:**
  - `out_x` = 0, `out_y` = 0, `out_opcode` = 3'b000;
  - `out_valid` = 0, `res_valid` = 0, `div0_err` = 0;
  - `count` = 0, both pointers = 0.
- **Push to issue:** command accepted at edge E → earliest `out_valid` = 1 after edge E+1.
- **Issue to result:** `out_valid` = 1 after edge N → ALU samples at edge N+1 → `res_valid` = 1 after edge N+1, coincident with the valid ALU `result`/`status`.
- **Push to result:** minimum 3 edges.
- **Throughput:** one command per cycle when not stalled.
- **Stall timing:** a stall sampled at edge N blocks the pop at edge N. A `res_valid` already in flight still asserts.
- **`count` updates:** on the same edge as the push/pop.

## Configuration
- **Macro:** `ALU_DIV0_GUARD_EN`.
- **Defined:** at issue, if opcode is 3'b011 or 3'b100 and y == 0:
  - `out_opcode` is forced to 3'b000, so the ALU passes x;
  - `div0_err` = 1 for exactly that issue cycle, same timing as `out_valid`;
  - `out_x`/`out_y` are loaded unmodified.
  - `div0_err` is 0 on every other cycle.
- **Not defined:** commands issue unmodified and `div0_err` is tied to 0.

## Test plan
- **Reset:** hold `areset` 2 cycles mid-traffic → all outputs 0, `count` = 0, `in_ready` = 0 during reset, 1 the cycle after.
- **Single command:** push x=20, y=6, op=3'b001 into an empty queue → `out_valid` one cycle after accept, `res_valid` the following cycle with ALU `result` = 26, `status` = 0.
- **Fill and wrap:**
  - hold `stall` = 1 and push 4 commands → `count` = 4, `in_ready` = 0, a 5th push is refused;
  - release `stall` → 4 issues on consecutive cycles in push order;
  - push 4 more → correct order across pointer wrap.
- **Simultaneous push/pop:** at `count` = 2 with `stall` = 0, push each cycle for 6 cycles → `count` stays 2, issue order matches push order.
- **Divide-by-zero guard:** push x=9, y=0, op=3'b011:
  - with `ALU_DIV0_GUARD_EN` defined → `out_opcode` = 3'b000, `div0_err` = 1 for one cycle, ALU `result` = 9;
  - without it → `out_opcode` = 3'b011, `div0_err` = 0.
- **Stall hold:** assert `stall` after one issue → `out_*` stable, `out_valid` = 0; the in-flight `res_valid` still asserts once.

Source files
------------

// File: rtl/alu_cmd_queue_if.sv
// Handshake and issue bus between the command source, alu_cmd_queue and the ALU.
// master = command source / ALU side, slave = alu_cmd_queue.
interface alu_cmd_queue_if #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 4
);
    logic                         in_valid;
    logic                         in_ready;
    logic [WIDTH-1:0]             in_x;
    logic [WIDTH-1:0]             in_y;
    logic [2:0]                   in_opcode;
    logic                         stall;
    logic [WIDTH-1:0]             out_x;
    logic [WIDTH-1:0]             out_y;
    logic [2:0]                   out_opcode;
    logic                         out_valid;
    logic                         res_valid;
    logic                         div0_err;
    logic [$clog2(DEPTH+1)-1:0]   count;

    modport master (
        output in_valid, in_x, in_y, in_opcode, stall,
        input  in_ready, out_x, out_y, out_opcode, out_valid, res_valid, div0_err, count
    );

    modport slave (
        input  in_valid, in_x, in_y, in_opcode, stall,
        output in_ready, out_x, out_y, out_opcode, out_valid, res_valid, div0_err, count
    );
endinterface

// File: rtl/alu_cmd_queue.sv
// Command FIFO and registered issue stage feeding the ALU, with res_valid aligned to the ALU result.
// Optional feature macro ALU_DIV0_GUARD_EN: divide/modulo-by-zero commands issue as pass-x and flag div0_err.
module alu_cmd_queue #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 4
) (
    input  logic           aclk,
    input  logic           areset,
    alu_cmd_queue_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic [2:0]       op;
    } entry_t;

`ifdef ALU_DIV0_GUARD_EN
    // Opcodes 3'b011 (divide) and 3'b100 (modulo) with a zero divisor.
    function automatic logic is_div0(input logic [2:0] op, input logic [WIDTH-1:0] y);
        return ((op == 3'b011) || (op == 3'b100)) && (y == {WIDTH{1'b0}});
    endfunction
`endif

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   out_x_q, out_x_d;
    logic [WIDTH-1:0]   out_y_q, out_y_d;
    logic [2:0]         out_opcode_q, out_opcode_d;
    logic               out_valid_q, out_valid_d;
    logic               res_valid_q, res_valid_d;
    logic               div0_err_q, div0_err_d;

    logic               full_s;
    logic               in_ready_s;
    logic               push_s;
    logic               pop_s;
    entry_t             head_s;

    // Next-state computation for FIFO storage, pointers, occupancy and issue registers.
    always_comb begin
        full_s       = (count_q == CNT_W'(DEPTH));
        in_ready_s   = !areset && !full_s;
        push_s       = bus.in_valid && in_ready_s;
        pop_s        = !bus.stall && (count_q != {CNT_W{1'b0}});
        head_s       = mem_q[rd_ptr_q];

        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        out_x_d      = out_x_q;
        out_y_d      = out_y_q;
        out_opcode_d = out_opcode_q;
        out_valid_d  = 1'b0;
        div0_err_d   = 1'b0;
        res_valid_d  = out_valid_q;

        if (push_s) begin
            mem_d[wr_ptr_q] = '{x: bus.in_x, y: bus.in_y, op: bus.in_opcode};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d        = wr_ptr_q;
        end

        // Without a pop the issue registers keep their values so the ALU recomputes the same command.
        if (pop_s) begin
            rd_ptr_d    = rd_ptr_q + PTR_W'(1);
            out_x_d     = head_s.x;
            out_y_d     = head_s.y;
            out_valid_d = 1'b1;
`ifdef ALU_DIV0_GUARD_EN
            if (is_div0(head_s.op, head_s.y)) begin
                out_opcode_d = 3'b000;
                div0_err_d   = 1'b1;
            end else begin
                out_opcode_d = head_s.op;
                div0_err_d   = 1'b0;
            end
`else
            out_opcode_d = head_s.op;
            div0_err_d   = 1'b0;
`endif
        end else begin
            rd_ptr_d    = rd_ptr_q;
            out_valid_d = 1'b0;
            div0_err_d  = 1'b0;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset discards queued entries and any pending res_valid.
    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q     <= {PTR_W{1'b0}};
            rd_ptr_q     <= {PTR_W{1'b0}};
            count_q      <= {CNT_W{1'b0}};
            out_x_q      <= {WIDTH{1'b0}};
            out_y_q      <= {WIDTH{1'b0}};
            out_opcode_q <= 3'b000;
            out_valid_q  <= 1'b0;
            res_valid_q  <= 1'b0;
            div0_err_q   <= 1'b0;
        end else begin
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            out_x_q      <= out_x_d;
            out_y_q      <= out_y_d;
            out_opcode_q <= out_opcode_d;
            out_valid_q  <= out_valid_d;
            res_valid_q  <= res_valid_d;
            div0_err_q   <= div0_err_d;
        end
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.out_x      = out_x_q;
    assign bus.out_y      = out_y_q;
    assign bus.out_opcode = out_opcode_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.div0_err   = div0_err_q;
    assign bus.count      = count_q;
endmodule

// File: tb/tb_alu_cmd_queue.sv
// Directed-vector bench for alu_cmd_queue with a scoreboard of expected issues and a decoupled monitor.
module tb_alu_cmd_queue;
    localparam int W = 13;
    localparam int D = 4;

    logic aclk;
    logic areset;

    alu_cmd_queue_if #(.WIDTH(W), .DEPTH(D)) bus_if ();

    alu_cmd_queue #(.WIDTH(W), .DEPTH(D)) dut (
        .aclk   (aclk),
        .areset (areset),
        .bus    (bus_if)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int vectors = 0;
    int miscompares = 0;

    // {x, y, opcode, div0_err} expected at each issue, in push order
    logic [2*W+3:0] exp_q [$];
    logic           prev_ov = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    function automatic logic [2*W+3:0] expect_issue(input logic [W-1:0] x, input logic [W-1:0] y,
                                                    input logic [2:0] op);
        logic [2:0] eop;
        logic       eerr;
        eop  = op;
        eerr = 1'b0;
`ifdef ALU_DIV0_GUARD_EN
        if (((op == 3'd3) || (op == 3'd4)) && (y == 13'd0)) begin
            eop  = 3'd0;
            eerr = 1'b1;
        end
`endif
        return {x, y, eop, eerr};
    endfunction

    // Monitor: compares every issue against the scoreboard and checks res_valid follows out_valid by one cycle.
    always @(negedge aclk) begin
        if (bus_if.out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_issue", 32'd1, 32'd0);
            end else begin
                logic [2*W+3:0] e;
                logic [2*W+3:0] a;
                e = exp_q.pop_front();
                a = {bus_if.out_x, bus_if.out_y, bus_if.out_opcode, bus_if.div0_err};
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL issue: got x=%0d y=%0d op=%0d err=%0d, required x=%0d y=%0d op=%0d err=%0d",
                             a[2*W+3:W+4], a[W+3:4], a[3:1], a[0],
                             e[2*W+3:W+4], e[W+3:4], e[3:1], e[0]);
                end
            end
        end else begin
            if (bus_if.div0_err !== 1'b0) chk("div0_err_idle", 32'(bus_if.div0_err), 32'd0);
        end
        if ((bus_if.res_valid === 1'b1) || prev_ov) begin
            chk("res_valid_align", 32'(bus_if.res_valid), 32'(prev_ov));
        end
        prev_ov = areset ? 1'b0 : (bus_if.out_valid === 1'b1);
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2:0] op);
        bus_if.in_valid  = 1'b1;
        bus_if.in_x      = x;
        bus_if.in_y      = y;
        bus_if.in_opcode = op;
        exp_q.push_back(expect_issue(x, y, op));
        tick();
        bus_if.in_valid  = 1'b0;
    endtask

    initial begin
        logic [W-1:0] held_x;
        int           budget;
        areset           = 1'b1;
        bus_if.in_valid  = 1'b0;
        bus_if.in_x      = 13'd0;
        bus_if.in_y      = 13'd0;
        bus_if.in_opcode = 3'd0;
        bus_if.stall     = 1'b0;
        tick();
        tick();
        chk("reset_in_ready", 32'(bus_if.in_ready), 32'd0);
        chk("reset_count", 32'(bus_if.count), 32'd0);
        chk("reset_outputs", {bus_if.out_x, bus_if.out_y, bus_if.out_opcode, bus_if.out_valid,
                              bus_if.res_valid, bus_if.div0_err}, 32'd0);
        areset = 1'b0;
        #1;
        chk("post_reset_in_ready", 32'(bus_if.in_ready), 32'd1);

        // Single command: 20 + 6
        push(13'd20, 13'd6, 3'b001);
        chk("single_no_bypass", 32'(bus_if.out_valid), 32'd0);
        chk("single_count", 32'(bus_if.count), 32'd1);
        tick();
        chk("single_out_valid", 32'(bus_if.out_valid), 32'd1);
        chk("single_out_x", 32'(bus_if.out_x), 32'd20);
        tick();
        chk("single_res_valid", 32'(bus_if.res_valid), 32'd1);
        chk("single_out_valid_drop", 32'(bus_if.out_valid), 32'd0);

        // Fill while stalled, then refuse a fifth push
        bus_if.stall = 1'b1;
        push(13'd1, 13'd2, 3'b001);
        push(13'd3, 13'd4, 3'b010);
        push(13'd5, 13'd6, 3'b101);
        push(13'd7, 13'd8, 3'b110);
        chk("fill_count", 32'(bus_if.count), 32'd4);
        chk("fill_in_ready", 32'(bus_if.in_ready), 32'd0);
        bus_if.in_valid  = 1'b1;
        bus_if.in_x      = 13'd99;
        bus_if.in_y      = 13'd99;
        bus_if.in_opcode = 3'b111;
        tick();
        bus_if.in_valid  = 1'b0;
        chk("fifth_refused", 32'(bus_if.count), 32'd4);
        bus_if.stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("drain_consecutive", 32'(bus_if.out_valid), 32'd1);
        end
        chk("drain_count", 32'(bus_if.count), 32'd0);

        // Four more across the pointer wrap
        push(13'd100, 13'd1, 3'b001);
        push(13'd200, 13'd2, 3'b010);
        push(13'd300, 13'd3, 3'b101);
        push(13'd8191, 13'd4, 3'b111);
        tick();
        tick();

        // Simultaneous push/pop at count 2
        bus_if.stall = 1'b1;
        push(13'd11, 13'd12, 3'b001);
        push(13'd13, 13'd14, 3'b010);
        chk("sim_pre_count", 32'(bus_if.count), 32'd2);
        bus_if.stall = 1'b0;
        for (int i = 0; i < 6; i++) begin
            push(13'(40 + i), 13'(50 + i), 3'(i));
            chk("sim_count_steady", 32'(bus_if.count), 32'd2);
        end
        tick();
        tick();
        tick();
        chk("sim_drained", 32'(bus_if.count), 32'd0);

        // Divide by zero
        push(13'd9, 13'd0, 3'b011);
        tick();
`ifdef ALU_DIV0_GUARD_EN
        chk("div0_opcode", 32'(bus_if.out_opcode), 32'd0);
        chk("div0_err", 32'(bus_if.div0_err), 32'd1);
`else
        chk("div0_opcode", 32'(bus_if.out_opcode), 32'd3);
        chk("div0_err", 32'(bus_if.div0_err), 32'd0);
`endif
        chk("div0_x", 32'(bus_if.out_x), 32'd9);
        tick();
        chk("div0_err_one_cycle", 32'(bus_if.div0_err), 32'd0);

        // Stall right after one issue
        push(13'd5, 13'd7, 3'b010);
        push(13'd11, 13'd13, 3'b100);
        chk("stall_first_issued", 32'(bus_if.out_valid), 32'd1);
        held_x = bus_if.out_x;
        bus_if.stall = 1'b1;
        tick();
        chk("stall_out_valid", 32'(bus_if.out_valid), 32'd0);
        chk("stall_res_inflight", 32'(bus_if.res_valid), 32'd1);
        chk("stall_hold_x", 32'(bus_if.out_x), 32'(held_x));
        tick();
        chk("stall_res_once", 32'(bus_if.res_valid), 32'd0);
        chk("stall_hold_y", 32'(bus_if.out_y), 32'd7);
        chk("stall_count", 32'(bus_if.count), 32'd1);
        bus_if.stall = 1'b0;
        tick();
        tick();

        // Reset mid-traffic discards queued work
        bus_if.stall = 1'b1;
        push(13'd21, 13'd22, 3'b001);
        push(13'd23, 13'd24, 3'b001);
        areset          = 1'b1;
        bus_if.in_valid = 1'b1;
        #1;
        chk("midreset_in_ready", 32'(bus_if.in_ready), 32'd0);
        tick();
        exp_q.delete();
        tick();
        bus_if.in_valid = 1'b0;
        chk("midreset_count", 32'(bus_if.count), 32'd0);
        chk("midreset_outputs", {bus_if.out_x, bus_if.out_y, bus_if.out_opcode, bus_if.out_valid,
                                 bus_if.res_valid, bus_if.div0_err}, 32'd0);
        areset       = 1'b0;
        bus_if.stall = 1'b0;
        #1;
        chk("midreset_ready_after", 32'(bus_if.in_ready), 32'd1);
        tick();
        chk("midreset_no_issue", 32'(bus_if.out_valid), 32'd0);

        // Final: one more command, then wait (bounded) for the scoreboard to drain
        push(13'd4095, 13'd1, 3'b001);
        budget = 0;
        while ((exp_q.size() != 0) && (budget < 20)) begin
            tick();
            budget++;
        end
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
